// File: rtl/bus_xfer_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bus_xfer_ctrl_pkg
//  Description : Shared definitions for the register-bus transfer sequencer:
//                register codes, code legality check and FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package bus_xfer_ctrl_pkg;

    // Register codes as seen on the bus-mux select and the load-strobe index
    localparam logic [3:0] CODE_RA = 4'b0000;
    localparam logic [3:0] CODE_RB = 4'b0001;
    localparam logic [3:0] CODE_RC = 4'b0010;
    localparam logic [3:0] CODE_R1 = 4'b0011;
    localparam logic [3:0] CODE_R2 = 4'b0100;
    localparam logic [3:0] CODE_R3 = 4'b0101;
    localparam logic [3:0] CODE_DR = 4'b0110;
    localparam logic [3:0] CODE_AR = 4'b0111;
    localparam logic [3:0] CODE_AC = 4'b1001;
    localparam logic [3:0] CODE_PC = 4'b1010;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        LOAD  = 2'd2
    } xfer_state_t;

    // A code is legal when it names one of the registers above; the argument
    // is zero-extended by the caller so any code width can be checked.
    function automatic logic code_is_legal(input logic [31:0] code);
        return (code <= {28'd0, CODE_AR}) ||
               (code == {28'd0, CODE_AC}) ||
               (code == {28'd0, CODE_PC});
    endfunction

endpackage : bus_xfer_ctrl_pkg
`default_nettype wire

// File: rtl/bus_xfer_ctrl_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : xfer_fifo
//  Description : Small synchronous FIFO for queued transfer requests. Pointers
//                carry one extra wrap bit so full and empty are distinct.
//  Revision    : 1.0 - initial release
// ============================================================================
module xfer_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int         AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] c_ptr_one = (AW + 1)'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_do_push;
    logic             w_do_pop;

    // A push into a full queue is dropped so queued entries are never overwritten
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    assign empty = (r_wptr == r_rptr);
    assign full  = (r_wptr[AW] != r_rptr[AW]) &&
                   (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign rdata = r_mem[r_rptr[AW-1:0]];

    // Pointer update; reset empties the queue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + c_ptr_one;
            if (w_do_pop)  r_rptr <= r_rptr + c_ptr_one;
        end
    end

    // Storage write; contents are only meaningful between the pointers
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= wdata;
    end

endmodule : xfer_fifo
`default_nettype wire

// File: rtl/bus_xfer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : bus_xfer_ctrl
//  Description : Register-bus transfer sequencer. Queues (src, dst) requests,
//                drives the bus-mux select, then pulses one load strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_xfer_ctrl #(
    parameter int FIFO_DEPTH = 2,
    parameter int CODE_W     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [CODE_W-1:0] req_src,
    input  logic [CODE_W-1:0] req_dst,
    input  logic              hold,
    output logic [CODE_W-1:0] bus_sel,
    output logic [15:0]       ld_en,
    output logic              xfer_done,
    output logic              xfer_err,
    output logic              busy
);

    import bus_xfer_ctrl_pkg::*;

    xfer_state_t         r_state,   w_state_nxt;
    logic [CODE_W-1:0]   r_bus_sel, w_bus_sel_nxt;
    logic [CODE_W-1:0]   r_dst,     w_dst_nxt;
    logic [15:0]         r_ld_en,   w_ld_en_nxt;
    logic                r_done,    w_done_nxt;
    logic                r_err,     w_err_nxt;

    logic                w_pop;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic [2*CODE_W-1:0] w_head;
    logic [CODE_W-1:0]   w_head_src;
    logic [CODE_W-1:0]   w_head_dst;
    logic                w_head_legal;

    xfer_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (2 * CODE_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (req_valid),
        .wdata ({req_src, req_dst}),
        .pop   (w_pop),
        .rdata (w_head),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    assign w_head_src   = w_head[2*CODE_W-1:CODE_W];
    assign w_head_dst   = w_head[CODE_W-1:0];
    assign w_head_legal = code_is_legal(32'(w_head_src)) &&
                          code_is_legal(32'(w_head_dst));

    // Next-state and next-output decode; strobes default to zero every cycle
    always_comb begin
        w_state_nxt   = r_state;
        w_bus_sel_nxt = r_bus_sel;
        w_dst_nxt     = r_dst;
        w_ld_en_nxt   = '0;
        w_done_nxt    = 1'b0;
        w_err_nxt     = 1'b0;
        w_pop         = 1'b0;
        case (r_state)
            // LOAD ends its strobe cycle exactly like IDLE: fetch the next
            // entry if one is waiting, which gives two-cycle throughput.
            IDLE, LOAD: begin
                w_state_nxt = IDLE;
                if (!w_fifo_empty) begin
                    w_pop = 1'b1;
                    if (w_head_legal) begin
                        w_bus_sel_nxt = w_head_src;
                        w_dst_nxt     = w_head_dst;
                        w_state_nxt   = DRIVE;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            // Bus settle cycle; hold stretches it before committing the load
            DRIVE: begin
                if (!hold) begin
                    w_ld_en_nxt = 16'd1 << r_dst;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = LOAD;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State and output registers; reset drops the load strobe immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_bus_sel <= '0;
            r_dst     <= '0;
            r_ld_en   <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_bus_sel <= w_bus_sel_nxt;
            r_dst     <= w_dst_nxt;
            r_ld_en   <= w_ld_en_nxt;
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
        end
    end

    assign req_ready = !w_fifo_full;
    assign busy      = (r_state != IDLE) || !w_fifo_empty;
    assign bus_sel   = r_bus_sel;
    assign ld_en     = r_ld_en;
    assign xfer_done = r_done;
    assign xfer_err  = r_err;

endmodule : bus_xfer_ctrl
`default_nettype wire

// File: tb/tb_bus_xfer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_xfer_ctrl
//  Description : Self-checking bench for bus_xfer_ctrl: directed scenarios and
//                a randomized run against an ordered event model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_xfer_ctrl;

    localparam int FIFO_DEPTH = 2;
    localparam int CODE_W     = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_src;
    logic [3:0]  req_dst;
    logic        hold;
    logic [3:0]  bus_sel;
    logic [15:0] ld_en;
    logic        xfer_done;
    logic        xfer_err;
    logic        busy;

    int total = 0;
    int bad   = 0;

    // One observed/expected bus event: an error discard or a load strobe
    typedef struct {
        bit          is_err;
        logic [15:0] ld;
        logic [3:0]  sel;
    } ev_t;

    ev_t log_q[$];
    ev_t exp_q[$];

    bus_xfer_ctrl #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .CODE_W     (CODE_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_src   (req_src),
        .req_dst   (req_dst),
        .hold      (hold),
        .bus_sel   (bus_sel),
        .ld_en     (ld_en),
        .xfer_done (xfer_done),
        .xfer_err  (xfer_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference model: what a single accepted request must eventually produce
    function automatic bit legal(input logic [3:0] c);
        return (c < 4'd8) || (c == 4'd9) || (c == 4'd10);
    endfunction

    function automatic ev_t model_ev(input logic [3:0] s, input logic [3:0] d);
        ev_t e;
        if (legal(s) && legal(d)) begin
            e.is_err = 1'b0;
            e.ld     = 16'h0001 << d;
            e.sel    = s;
        end else begin
            e.is_err = 1'b1;
            e.ld     = 16'h0000;
            e.sel    = 4'h0;
        end
        return e;
    endfunction

    function automatic logic [3:0] pick_code();
        logic [3:0] lg [10] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10};
        logic [3:0] il [6]  = '{4'd8, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};
        if ($urandom_range(0, 9) < 8) return lg[$urandom_range(0, 9)];
        return il[$urandom_range(0, 5)];
    endfunction

    // Mid-cycle monitor: logs events and checks strobe shape on every active cycle
    always @(negedge clk) begin
        if (rst_n) begin
            if (xfer_err)      log_q.push_back('{1'b1, 16'h0000, 4'h0});
            if (ld_en != 16'h0) log_q.push_back('{1'b0, ld_en, bus_sel});
            if (ld_en != 16'h0 || xfer_done || xfer_err) begin
                total++;
                if (!((xfer_done ? $onehot(ld_en) : (ld_en == 16'h0)) && !(xfer_done && xfer_err))) begin
                    bad++;
                    $display("FAIL strobe_shape: ld_en=%h xfer_done=%b xfer_err=%b, required one-hot ld_en only with xfer_done", ld_en, xfer_done, xfer_err);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Run until the sequencer is idle; ok=0 if it never gets there
    task automatic drain(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_src = '0; req_dst = '0; hold = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({bus_sel, ld_en, xfer_done, xfer_err, busy, req_ready} !== {4'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL reset_in: sel=%h ld=%h done=%b err=%b busy=%b rdy=%b, required 0 0 0 0 0 1", bus_sel, ld_en, xfer_done, xfer_err, busy, req_ready);
        end
        @(negedge clk) rst_n = 1'b1;
        step();
        total++;
        if ({bus_sel, ld_en, xfer_done, xfer_err, busy, req_ready} !== {4'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL reset_out: sel=%h ld=%h done=%b err=%b busy=%b rdy=%b, required 0 0 0 0 0 1", bus_sel, ld_en, xfer_done, xfer_err, busy, req_ready);
        end
    endtask

    task automatic test_single();
        req_src = 4'b0011; req_dst = 4'b1001; req_valid = 1'b1; hold = 1'b0;
        step();                              // E0: accepted
        req_valid = 1'b0;
        step();                              // E1
        total++;
        if (bus_sel !== 4'b0011 || ld_en !== 16'h0) begin
            bad++;
            $display("FAIL single_e1: sel=%h ld=%h, required sel=3 ld=0000", bus_sel, ld_en);
        end
        step();                              // E2
        total++;
        if (ld_en !== 16'h0200 || xfer_done !== 1'b1 || bus_sel !== 4'b0011) begin
            bad++;
            $display("FAIL single_e2: ld=%h done=%b sel=%h, required ld=0200 done=1 sel=3", ld_en, xfer_done, bus_sel);
        end
        step();                              // E3
        total++;
        if (ld_en !== 16'h0 || xfer_done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL single_e3: ld=%h done=%b busy=%b, required 0 0 0", ld_en, xfer_done, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  exp_sel [4] = '{4'b1010, 4'b1010, 4'b0110, 4'b0110};
        logic [15:0] exp_ld  [4] = '{16'h0000, 16'h0080, 16'h0000, 16'h0001};
        req_src = 4'b1010; req_dst = 4'b0111; req_valid = 1'b1;
        step();                              // E0
        req_src = 4'b0110; req_dst = 4'b0000;
        for (int c = 0; c < 4; c++) begin
            step();                          // E1..E4
            req_valid = 1'b0;
            total++;
            if (bus_sel !== exp_sel[c] || ld_en !== exp_ld[c]) begin
                bad++;
                $display("FAIL b2b_cycle%0d: sel=%h ld=%h, required sel=%h ld=%h", c + 1, bus_sel, ld_en, exp_sel[c], exp_ld[c]);
            end
        end
        step();
    endtask

    task automatic test_full();
        logic [3:0] s [4] = '{4'd4, 4'd7, 4'd9, 4'd0};
        logic [3:0] d [4] = '{4'd5, 4'd3, 4'd1, 4'd6};
        int  idx = 0;
        bit  acc;
        bit  ok;
        log_q.delete(); exp_q.delete();
        hold = 1'b1;
        req_valid = 1'b1; req_src = s[0]; req_dst = d[0];
        for (int c = 0; c < 20 && idx < 3; c++) begin
            @(negedge clk) acc = req_ready;
            step();
            if (acc) begin
                exp_q.push_back(model_ev(s[idx], d[idx]));
                idx++;
                req_src = s[idx]; req_dst = d[idx];
            end
        end
        // fourth request stays offered while the queue is full
        for (int c = 0; c < 3; c++) begin
            total++;
            if (req_ready !== 1'b0) begin
                bad++;
                $display("FAIL full_ready%0d: req_ready=%b, required 0", c, req_ready);
            end
            step();
        end
        req_valid = 1'b0;
        hold = 1'b0;
        drain(ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL full_drain: busy never fell, required idle within 60 cycles");
        end
        total++;
        if (log_q.size() != exp_q.size() || exp_q.size() != 3) begin
            bad++;
            $display("FAIL full_count: observed %0d events, required 3 (model %0d)", log_q.size(), exp_q.size());
        end
        for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (log_q[i].is_err !== exp_q[i].is_err || log_q[i].ld !== exp_q[i].ld || log_q[i].sel !== exp_q[i].sel) begin
                bad++;
                $display("FAIL full_ev%0d: err=%b ld=%h sel=%h, required err=%b ld=%h sel=%h", i, log_q[i].is_err, log_q[i].ld, log_q[i].sel, exp_q[i].is_err, exp_q[i].ld, exp_q[i].sel);
            end
        end
    endtask

    task automatic test_hold();
        bit ok;
        hold = 1'b1;
        req_src = 4'b0101; req_dst = 4'b0100; req_valid = 1'b1;
        step();                              // E0
        req_valid = 1'b0;
        step();                              // E1: now in DRIVE
        for (int c = 0; c < 3; c++) begin
            step();                          // hold sampled high
            total++;
            if (ld_en !== 16'h0 || bus_sel !== 4'b0101) begin
                bad++;
                $display("FAIL hold_stall%0d: ld=%h sel=%h, required ld=0000 sel=5", c, ld_en, bus_sel);
            end
        end
        hold = 1'b0;
        step();
        total++;
        if (ld_en !== 16'h0010 || bus_sel !== 4'b0101) begin
            bad++;
            $display("FAIL hold_release: ld=%h sel=%h, required ld=0010 sel=5", ld_en, bus_sel);
        end
        drain(ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL hold_drain: busy never fell, required idle");
        end
    endtask

    task automatic test_illegal();
        bit ok;
        log_q.delete();
        req_src = 4'b1100; req_dst = 4'b0001; req_valid = 1'b1;
        step();                              // E0
        req_src = 4'b0001; req_dst = 4'b0010;
        step();                              // E1: illegal entry discarded
        req_valid = 1'b0;
        total++;
        if (xfer_err !== 1'b1 || ld_en !== 16'h0 || bus_sel !== 4'b0101) begin
            bad++;
            $display("FAIL illegal_err: err=%b ld=%h sel=%h, required err=1 ld=0000 sel=5", xfer_err, ld_en, bus_sel);
        end
        step();                              // E2
        total++;
        if (xfer_err !== 1'b0 || bus_sel !== 4'b0001) begin
            bad++;
            $display("FAIL illegal_next: err=%b sel=%h, required err=0 sel=1", xfer_err, bus_sel);
        end
        drain(ok);
        total++;
        if (!ok || log_q.size() != 2) begin
            bad++;
            $display("FAIL illegal_count: idle=%b events=%0d, required idle=1 events=2", ok, log_q.size());
        end else begin
            total++;
            if (!log_q[0].is_err || log_q[1].is_err || log_q[1].ld !== 16'h0004 || log_q[1].sel !== 4'b0001) begin
                bad++;
                $display("FAIL illegal_seq: first err=%b, second err=%b ld=%h sel=%h, required 1 / 0 0004 1", log_q[0].is_err, log_q[1].is_err, log_q[1].ld, log_q[1].sel);
            end
        end
    endtask

    task automatic test_reset_mid_load();
        req_src = 4'b1010; req_dst = 4'b0010; req_valid = 1'b1;
        step();                              // E0
        req_src = 4'b0000; req_dst = 4'b0001;
        step();                              // E1
        req_valid = 1'b0;
        step();                              // E2: LOAD, second entry queued
        total++;
        if (ld_en !== 16'h0004) begin
            bad++;
            $display("FAIL rst_pre: ld=%h, required 0004", ld_en);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (ld_en !== 16'h0 || busy !== 1'b0 || bus_sel !== 4'h0) begin
            bad++;
            $display("FAIL rst_async: ld=%h busy=%b sel=%h, required 0000 0 0", ld_en, busy, bus_sel);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        log_q.delete();
        step();
        total++;
        if ({bus_sel, ld_en, busy, req_ready} !== {4'h0, 16'h0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL rst_after: sel=%h ld=%h busy=%b rdy=%b, required 0 0000 0 1", bus_sel, ld_en, busy, req_ready);
        end
        repeat (6) step();
        total++;
        if (log_q.size() != 0) begin
            bad++;
            $display("FAIL rst_lost_queue: %0d events after reset, required 0", log_q.size());
        end
    endtask

    task automatic test_random();
        bit ok;
        log_q.delete(); exp_q.delete();
        for (int i = 0; i < 300; i++) begin
            req_valid = ($urandom_range(0, 99) < 60);
            req_src   = pick_code();
            req_dst   = pick_code();
            hold      = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            if (req_valid && req_ready) exp_q.push_back(model_ev(req_src, req_dst));
            step();
        end
        req_valid = 1'b0;
        hold = 1'b0;
        drain(ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL rand_drain: busy never fell, required idle");
        end
        total++;
        if (log_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL rand_count: observed %0d events, required %0d", log_q.size(), exp_q.size());
        end
        for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (log_q[i].is_err !== exp_q[i].is_err || log_q[i].ld !== exp_q[i].ld || log_q[i].sel !== exp_q[i].sel) begin
                bad++;
                $display("FAIL rand_ev%0d: err=%b ld=%h sel=%h, required err=%b ld=%h sel=%h", i, log_q[i].is_err, log_q[i].ld, log_q[i].sel, exp_q[i].is_err, exp_q[i].ld, exp_q[i].sel);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_hold();
        test_illegal();
        test_reset_mid_load();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_bus_xfer_ctrl
`default_nettype wire

// File: doc/bus_xfer_ctrl.md
Name: bus_xfer_ctrl

Overview:
Sequencer for the shared 16-bit register bus. It accepts register-to-register transfer requests (source code, destination code) from the control unit and buffers them in a small FIFO. For each request it drives the bus-mux select and then pulses exactly one destination load enable. It sits between the instruction decoder/microsequencer and the bus mux plus the register load strobes.

Parameters:
FIFO_DEPTH, 2, request queue depth; must be a power of 2 and at least 2.
CODE_W, 4, width of the source/destination register codes.

Ports:
clk  in  1  system clock; all state changes on the rising edge.
rst_n  in  1  asynchronous active-low reset.
req_valid  in  1  transfer request present.
req_ready  out  1  FIFO can accept; equals !full.
req_src  in  CODE_W  source code: RA=0000, RB=0001, RC=0010, R1=0011, R2=0100, R3=0101, DR=0110, AR=0111, AC=1001, PC=1010.
req_dst  in  CODE_W  destination code; same encoding as req_src.
hold  in  1  stall; extends the DRIVE state, e.g. for a memory wait.
bus_sel  out  CODE_W  registered select to the bus mux.
ld_en  out  16  one-hot load strobe; bit index equals the destination code.
xfer_done  out  1  one-cycle pulse, coincident with ld_en.
xfer_err  out  1  one-cycle pulse when an entry with an illegal code is discarded.
busy  out  1  high when the FSM is not in IDLE or the FIFO is non-empty.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: bus_sel=0000, ld_en=0, xfer_done=0, xfer_err=0, busy=0, FIFO empty, state IDLE.
- Reset asserted mid-transfer clears ld_en immediately (asynchronously). Any queued requests are lost.
- Handshake: a request is accepted on a rising edge where req_valid && req_ready. Codes are captured at that edge.
- When the FIFO is full, req_ready=0 and req_valid is ignored. In-flight requests are never overwritten.
- FIFO: read/write pointers use log2(FIFO_DEPTH)+1 bits, so full and empty are distinguished by the wrap bit.
- Simultaneous push and pop while non-full is legal. Occupancy is unchanged in that cycle.
- Legal codes: 0000–0111, 1001 and 1010. Codes 1000 and 1011–1111 are illegal.
- An entry is illegal if either its src or dst is illegal. It is checked when popped, not when pushed.
- FSM states: IDLE, DRIVE, LOAD.
- IDLE, FIFO empty: outputs hold. bus_sel keeps its last value; ld_en=0.
- IDLE, FIFO non-empty: pop the head entry.
  - Legal entry: bus_sel<=src, latch dst, go to DRIVE.
  - Illegal entry: xfer_err<=1 for one cycle, bus_sel unchanged, stay in IDLE.
- DRIVE: bus settle cycle.
  - hold=1: stay in DRIVE. bus_sel is held and ld_en=0.
  - hold=0: ld_en<=onehot(dst), xfer_done<=1, go to LOAD.
- LOAD: ld_en is high for exactly this one cycle and bus_sel is still src. The destination captures at the end of the cycle.
  - At the LOAD→next edge, ld_en and xfer_done clear.
  - If the FIFO is non-empty, pop in the same edge and treat the entry as IDLE does (legal → DRIVE, illegal → xfer_err and go to IDLE).
  - Otherwise go to IDLE.
- Latency with an empty pipeline and hold=0:
  - request accepted at edge E0;
  - bus_sel updates at E1;
  - ld_en and xfer_done are high from E2 to E3.
- Throughput: one transfer per 2 cycles back-to-back.
- hold is sampled only in DRIVE. It has no effect in IDLE or LOAD.
- src==dst is legal. The transfer runs as a normal load.
- ld_en is never multi-hot, and never asserts in a cycle where bus_sel differs from the active src.

Decomposition:
- Shared package (defines/include):
  - register code constants: CODE_RA … CODE_PC;
  - a legality function for codes;
  - FSM state encodings: IDLE=2'd0, DRIVE=2'd1, LOAD=2'd2.
- One sub-module, xfer_fifo: a parameterised synchronous FIFO of width 2*CODE_W, with push/pop/full/empty. The controller FSM and output registers stay in bus_xfer_ctrl.

Test Plan:
- Single transfer: push src=0011 (R1), dst=1001 (AC), hold=0.
  - Expect bus_sel=0011 at E1.
  - Expect ld_en=16'h0200 and xfer_done=1 for exactly one cycle at E2.
  - Expect busy low from E3.
- Back-to-back queue: push {1010→0111} and {0110→0000} on consecutive cycles.
  - Expect ld_en=16'h0080, then ld_en=16'h0001 two cycles later.
  - bus_sel sequence 1010, 1010, 0110, 0110.
- Full FIFO: push 3 requests without draining. req_ready must drop after the FIFO holds 2 entries.
  - Keep req_valid high.
  - Expect exactly 3 transfers in order, with none duplicated or lost.
- Hold stall: hold=1 for 3 cycles during DRIVE of {0101→0100}.
  - ld_en stays 0 and bus_sel stays 0101.
  - ld_en=16'h0010 appears the cycle after hold falls.
- Illegal code: push {1100→0001}, then {0001→0010}.
  - Expect one xfer_err pulse and no ld_en for the first entry.
  - The second entry completes with ld_en=16'h0004.
- Reset mid-LOAD: assert rst_n=0 asynchronously while ld_en is high.
  - ld_en clears before the next clock edge.
  - After release: FIFO empty, bus_sel=0000, state IDLE.
